// File: rtl/sat_counter_table.sv
// sat_counter_table: pattern history table of saturating up/down counters.
// The table owns the saturating read-modify-write, sweeps every entry to
// weak-not-taken after reset, and can optionally forward a same-cycle update
// to the lookup port. Lookup is purely combinational; update is one write per
// cycle from the resolve stage.
module sat_counter_table #(
  parameter int unsigned WIDTH    = 2,  // counter width, 1..8; MSB = taken
  parameter int unsigned IDX_BITS = 8,  // depth = 2**IDX_BITS
  parameter int unsigned BYPASS   = 0   // 1: forward same-index update to lookup
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] lookup_idx,
  output logic [WIDTH-1:0]    pred_count,
  output logic                pred_taken,
  input  logic                update_valid,
  input  logic [IDX_BITS-1:0] update_idx,
  input  logic                update_taken,
  output logic                ready
);

  localparam int unsigned DEPTH = 1 << IDX_BITS;

  // Weak-not-taken: largest value whose MSB is still 0 (01 for 2 bits, 0 for 1).
  localparam logic [WIDTH-1:0] WNT     = WIDTH'((1 << (WIDTH - 1)) - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_MIN = '0;

  typedef enum logic {
    ST_INIT = 1'b0,  // sweeping WNT into the table, lookups forced to WNT
    ST_RUN  = 1'b1   // table valid, updates accepted
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] ptr_q, ptr_d;

  logic [WIDTH-1:0]    mem_q [DEPTH];

  logic                upd_en;
  logic [WIDTH-1:0]    upd_cur;
  logic [WIDTH-1:0]    upd_next;

  logic                wr_en;
  logic [IDX_BITS-1:0] wr_idx;
  logic [WIDTH-1:0]    wr_data;

  // Saturating step: compare against the bounds so the counter never wraps.
  function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] cur,
                                                input logic             up);
    logic [WIDTH-1:0] nxt;
    if (up) begin
      nxt = (cur == CNT_MAX) ? cur : cur + 1'b1;
    end else begin
      nxt = (cur == CNT_MIN) ? cur : cur - 1'b1;
    end
    return nxt;
  endfunction

  // Updates only count once the table is valid; during the sweep they are dropped.
  assign upd_en   = (state_q == ST_RUN) && update_valid;
  assign upd_cur  = mem_q[update_idx];
  assign upd_next = sat_step(upd_cur, update_taken);

  // Sweep pointer and state: advance through every entry, then settle in RUN.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // State register; reset pulls the FSM back to the start of the sweep immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of the others, independent of statement order.
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Single write port: the sweep owns it in INIT, the resolve update in RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    wr_data = WNT;
    if (state_q == ST_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = ptr_q;
      wr_data = WNT;
    end else if (upd_en) begin
      wr_en   = 1'b1;
      wr_idx  = update_idx;
      wr_data = upd_next;
    end
  end

  // Counter storage; contents become defined only through the sweep.
  always_ff @(posedge clk) begin
    // NOTE: the array deliberately has no reset term; a reset on every entry
    // would turn it into flops with a huge reset fan-out, and the sweep already
    // defines the contents before ready rises.
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Lookup: WNT while sweeping, otherwise the stored value or the forwarded update.
  always_comb begin
    pred_count = WNT;
    if (state_q == ST_RUN) begin
      pred_count = mem_q[lookup_idx];
      if ((BYPASS != 0) && update_valid && (lookup_idx == update_idx)) begin
        pred_count = upd_next;
      end
    end
  end

  assign pred_taken = pred_count[WIDTH-1];

  // ready is a straight decode of the one-bit state flop, so it cannot glitch.
  assign ready = (state_q == ST_RUN);

endmodule

// File: tb/tb_sat_counter_table.sv
// Bench for sat_counter_table: three instances (2-bit/16-entry without and
// with bypass sharing one stimulus, 3-bit/256-entry) compared against an
// array-based reference model of the counter table.
module tb_sat_counter_table;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two 16-entry instances
  logic       rst_ab;
  logic [3:0] lk_ab, ui_ab;
  logic       uv_ab, ut_ab;
  logic [1:0] pc_a, pc_b;
  logic       pt_a, pt_b, rdy_a, rdy_b;

  // Stimulus for the 256-entry, 3-bit instance
  logic       rst_c;
  logic [7:0] lk_c, ui_c;
  logic       uv_c, ut_c;
  logic [2:0] pc_c;
  logic       pt_c, rdy_c;

  sat_counter_table #(.WIDTH(2), .IDX_BITS(4), .BYPASS(0)) u_a (
    .clk(clk), .rst(rst_ab), .lookup_idx(lk_ab), .pred_count(pc_a),
    .pred_taken(pt_a), .update_valid(uv_ab), .update_idx(ui_ab),
    .update_taken(ut_ab), .ready(rdy_a));

  sat_counter_table #(.WIDTH(2), .IDX_BITS(4), .BYPASS(1)) u_b (
    .clk(clk), .rst(rst_ab), .lookup_idx(lk_ab), .pred_count(pc_b),
    .pred_taken(pt_b), .update_valid(uv_ab), .update_idx(ui_ab),
    .update_taken(ut_ab), .ready(rdy_b));

  sat_counter_table #(.WIDTH(3), .IDX_BITS(8), .BYPASS(0)) u_c (
    .clk(clk), .rst(rst_c), .lookup_idx(lk_c), .pred_count(pc_c),
    .pred_taken(pt_c), .update_valid(uv_c), .update_idx(ui_c),
    .update_taken(ut_c), .ready(rdy_c));

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int ma [16];
  int mc [256];
  bit ready_ab_m, ready_c_m;
  int init_ab_m, init_c_m;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input bit up, input int maxv);
    if (up) return (v >= maxv) ? maxv : v + 1;
    return (v <= 0) ? 0 : v - 1;
  endfunction

  // One cycle on the 16-entry pair; entered just after a falling edge.
  task automatic cycle_ab(input bit v, input int ui, input bit t, input int lk);
    int exp_a, exp_b;
    uv_ab = v; ui_ab = 4'(ui); ut_ab = t; lk_ab = 4'(lk);
    #1;
    exp_a = ready_ab_m ? ma[lk] : 1;
    exp_b = (ready_ab_m && v && ui == lk) ? sat(ma[ui], t, 3) : exp_a;
    check("ready_a", int'(rdy_a), int'(ready_ab_m));
    check("ready_b", int'(rdy_b), int'(ready_ab_m));
    check("count_a", int'(pc_a), exp_a);
    check("taken_a", int'(pt_a), exp_a / 2);
    check("count_b", int'(pc_b), exp_b);
    check("taken_b", int'(pt_b), exp_b / 2);
    @(posedge clk);
    if (rst_ab) begin
      ready_ab_m = 1'b0;
      init_ab_m  = 0;
    end else if (!ready_ab_m) begin
      init_ab_m++;
      if (init_ab_m == 16) begin
        ready_ab_m = 1'b1;
        foreach (ma[i]) ma[i] = 1;
      end
    end else if (v) begin
      ma[ui] = sat(ma[ui], t, 3);
    end
    @(negedge clk);
  endtask

  // One cycle on the 256-entry instance; entered just after a falling edge.
  task automatic cycle_c(input bit v, input int ui, input bit t, input int lk);
    int exp_c;
    uv_c = v; ui_c = 8'(ui); ut_c = t; lk_c = 8'(lk);
    #1;
    exp_c = ready_c_m ? mc[lk] : 3;
    check("ready_c", int'(rdy_c), int'(ready_c_m));
    check("count_c", int'(pc_c), exp_c);
    check("taken_c", int'(pt_c), exp_c / 4);
    @(posedge clk);
    if (rst_c) begin
      ready_c_m = 1'b0;
      init_c_m  = 0;
    end else if (!ready_c_m) begin
      init_c_m++;
      if (init_c_m == 256) begin
        ready_c_m = 1'b1;
        foreach (mc[i]) mc[i] = 3;
      end
    end else if (v) begin
      mc[ui] = sat(mc[ui], t, 7);
    end
    @(negedge clk);
  endtask

  // Raise reset between edges, confirm ready drops without a clock edge, hold, release.
  task automatic reset_ab();
    #2;
    rst_ab = 1'b1;
    #1;
    check("rst_async_ready_a", int'(rdy_a), 0);
    check("rst_async_ready_b", int'(rdy_b), 0);
    check("rst_async_count_a", int'(pc_a), 1);
    ready_ab_m = 1'b0;
    init_ab_m  = 0;
    @(negedge clk);
    cycle_ab(0, 0, 0, 0);
    cycle_ab(0, 0, 0, 0);
    rst_ab = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_up [4]   = '{2, 3, 3, 3};
    int exp_dn [5]   = '{2, 1, 0, 0, 0};
    int exp_c_up [5] = '{4, 5, 6, 7, 7};
    int edges;

    rst_ab = 1'b1; lk_ab = '0; ui_ab = '0; uv_ab = 1'b0; ut_ab = 1'b0;
    rst_c  = 1'b1; lk_c  = '0; ui_c  = '0; uv_c  = 1'b0; ut_c  = 1'b0;
    ready_ab_m = 1'b0; init_ab_m = 0;
    ready_c_m  = 1'b0; init_c_m  = 0;
    foreach (ma[i]) ma[i] = 1;
    foreach (mc[i]) mc[i] = 3;

    // Initial reset of the 16-entry pair
    @(negedge clk);
    cycle_ab(0, 0, 0, 0);
    cycle_ab(0, 0, 0, 0);
    rst_ab = 1'b0;

    // Sweep: taken updates to idx 5 throughout INIT must be dropped
    for (int i = 0; i < 16; i++) cycle_ab(1, 5, 1, i);
    for (int i = 0; i < 16; i++) cycle_ab(0, 0, 0, i);
    uv_ab = 1'b0; lk_ab = 4'd5;
    #1;
    check("idx5_after_init", int'(pc_a), 1);

    // Saturation upward then downward on idx 3, back-to-back
    for (int k = 0; k < 4; k++) begin
      cycle_ab(1, 3, 1, 3);
      uv_ab = 1'b0; lk_ab = 4'd3;
      #1;
      check("sat_up_idx3", int'(pc_a), exp_up[k]);
    end
    for (int k = 0; k < 5; k++) begin
      cycle_ab(1, 3, 0, 3);
      uv_ab = 1'b0; lk_ab = 4'd3;
      #1;
      check("sat_dn_idx3", int'(pc_a), exp_dn[k]);
    end
    @(negedge clk);

    // Same-cycle lookup and update on idx 7 (entry currently 01)
    uv_ab = 1'b1; ui_ab = 4'd7; ut_ab = 1'b1; lk_ab = 4'd7;
    #1;
    check("bypass_count_b", int'(pc_b), 2);
    check("bypass_taken_b", int'(pt_b), 1);
    check("nobypass_count_a", int'(pc_a), 1);
    check("nobypass_taken_a", int'(pt_a), 0);
    @(posedge clk);
    ma[7] = sat(ma[7], 1'b1, 3);
    @(negedge clk);
    uv_ab = 1'b0;
    #1;
    check("nobypass_next_a", int'(pc_a), 2);
    @(negedge clk);

    // Randomised traffic, lookups frequently colliding with the update index
    for (int n = 0; n < 400; n++) begin
      int ui, lk;
      ui = int'($urandom_range(0, 15));
      lk = ($urandom_range(0, 1) == 1) ? ui : int'($urandom_range(0, 15));
      cycle_ab($urandom_range(0, 3) != 0, ui, $urandom_range(0, 1) == 1, lk);
    end

    // Mid-run reset: drive idx 2 to 11, then reset between edges
    for (int k = 0; k < 3; k++) cycle_ab(1, 2, 1, 2);
    uv_ab = 1'b0; lk_ab = 4'd2;
    #1;
    check("idx2_saturated", int'(pc_a), 3);
    reset_ab();
    for (int i = 0; i < 16; i++) cycle_ab(0, 0, 0, 2);
    uv_ab = 1'b0; lk_ab = 4'd2;
    #1;
    check("idx2_after_resweep", int'(pc_a), 1);
    check("ready_after_resweep", int'(rdy_a), 1);
    @(negedge clk);

    // 3-bit, 256-entry instance: sweep length and init value
    cycle_c(0, 0, 0, 0);
    rst_c = 1'b0;
    edges = 0;
    while (!ready_c_m && edges < 1000) begin
      cycle_c(0, 0, 0, int'($urandom_range(0, 255)));
      edges++;
    end
    check("init_edges_c", edges, 256);
    uv_c = 1'b0; lk_c = 8'd0;
    #1;
    check("init_value_c", int'(pc_c), 3);
    check("ready_c_up", int'(rdy_c), 1);
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      cycle_c(1, 0, 1, 0);
      uv_c = 1'b0; lk_c = 8'd0;
      #1;
      check("sat_up_c_idx0", int'(pc_c), exp_c_up[k]);
    end
    @(negedge clk);
    cycle_c(0, 0, 0, 255);
    cycle_c(1, 255, 0, 255);
    cycle_c(1, 255, 0, 255);
    uv_c = 1'b0; lk_c = 8'd255;
    #1;
    check("idx255_independent", int'(pc_c), 1);
    lk_c = 8'd0;
    #1;
    check("idx0_independent", int'(pc_c), 7);
    @(negedge clk);

    for (int n = 0; n < 300; n++) begin
      cycle_c($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
              $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
